// File: rtl/calculadora_pkg.sv
// Shared definitions for the keypad entry sequencer and the calculator:
// operation codes, key codes, the entry FSM state enum and the
// operand accumulate helper.
package calculadora_pkg;

  // Operation codes presented on codigo (also decoded by the calculator)
  localparam logic [2:0] OP_NADA    = 3'b000;
  localparam logic [2:0] OP_PASSA_A = 3'b001;
  localparam logic [2:0] OP_PASSA_B = 3'b010;
  localparam logic [2:0] OP_SOMA    = 3'b011;
  localparam logic [2:0] OP_SUB     = 3'b100;

  // Key codes from the scanner; 0x0-0x9 are digits, 0xE/0xF unused
  localparam logic [3:0] TECLA_MAIS  = 4'hA;
  localparam logic [3:0] TECLA_MENOS = 4'hB;
  localparam logic [3:0] TECLA_IGUAL = 4'hC;
  localparam logic [3:0] TECLA_LIMPA = 4'hD;
  localparam logic [3:0] TECLA_DIGITO_MAX = 4'h9;

  // Entry FSM states; the encoding is what the display reads on estado
  typedef enum logic [1:0] {
    ST_OPER_A = 2'b00,
    ST_OPER_B = 2'b01,
    ST_PRONTO = 2'b10
  } estado_t;

  // Append one decimal digit to an operand, saturating at 255.
  // The 12-bit intermediate holds the worst case 255*10+9 = 2559.
  function automatic logic [7:0] acumula_digito(input logic [7:0] val,
                                                input logic [3:0] d);
    logic [11:0] soma;
    soma = ({4'd0, val} * 12'd10) + {8'd0, d};
    return (soma > 12'd255) ? 8'hFF : soma[7:0];
  endfunction

endpackage

// File: rtl/sincronizador_tecla.sv
// Brings the asynchronous scanner levels into the clk domain: a two-flop
// synchronizer on strobe and key code, then a registered rising-edge detect
// so a held key yields a single one-cycle internal strobe. Total latency
// from input change to strobe seen by the FSM is 3 cycles.
// Used only when CONTROLE_ENTRADA_SINC_EN is defined.
module sincronizador_tecla
  import calculadora_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_tecla_valida,
  input  logic [3:0] i_tecla,
  output logic       o_strobe,
  output logic [3:0] o_tecla
);

  logic       r_valida_s1;
  logic       r_valida_s2;
  logic       r_valida_s3;
  logic [3:0] r_tecla_s1;
  logic [3:0] r_tecla_s2;
  logic       r_strobe;
  logic [3:0] r_tecla_out;
  logic       w_borda;

  assign w_borda = r_valida_s2 & ~r_valida_s3;

  // Two-flop synchronizer plus history flop for the edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valida_s1 <= 1'b0;
      r_valida_s2 <= 1'b0;
      r_valida_s3 <= 1'b0;
      r_tecla_s1  <= 4'd0;
      r_tecla_s2  <= 4'd0;
    end else begin
      r_valida_s1 <= i_tecla_valida;
      r_valida_s2 <= r_valida_s1;
      r_valida_s3 <= r_valida_s2;
      r_tecla_s1  <= i_tecla;
      r_tecla_s2  <= r_tecla_s1;
    end
  end

  // Register the edge pulse together with the key it belongs to
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_strobe    <= 1'b0;
      r_tecla_out <= 4'd0;
    end else begin
      r_strobe    <= w_borda;
      r_tecla_out <= r_tecla_s2;
    end
  end

  assign o_strobe = r_strobe;
  assign o_tecla  = r_tecla_out;

endmodule

// File: rtl/controle_entrada.sv
// Keypad entry sequencer feeding the combinational calculator.
// Builds operand A, operand B and the operation code from digit/operator
// keys and pulses valido for one cycle when '=' completes an operation.
//
// Handshake: tecla is qualified only by tecla_valida; every cycle where the
// (internal) strobe is high consumes exactly one key, there is no ready and
// no back-pressure, so strobes on consecutive cycles are all processed.
// valido is a pure one-cycle output strobe with no acknowledge.
//
// Optional macro CONTROLE_ENTRADA_SINC_EN: treat the scanner inputs as
// asynchronous levels and route them through sincronizador_tecla
// (adds 3 cycles of latency, a held key counts once).
module controle_entrada
  import calculadora_pkg::*;
#(
  parameter int MAX_DIGITOS = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tecla_valida,
  input  logic [3:0] tecla,
  output logic [7:0] entrada_A,
  output logic [7:0] entrada_B,
  output logic [2:0] codigo,
  output logic       valido,
  output logic [1:0] estado
);

  localparam int CW = $clog2(MAX_DIGITOS + 1);
  localparam logic [CW-1:0] CONT_MAX = CW'(MAX_DIGITOS);
  localparam logic [CW-1:0] CONT_UM  = CW'(1);

  localparam logic [1:0] S_OPER_A = ST_OPER_A;
  localparam logic [1:0] S_OPER_B = ST_OPER_B;
  localparam logic [1:0] S_PRONTO = ST_PRONTO;

  // Key path as seen by the FSM (direct or synchronized)
  logic       w_strobe;
  logic [3:0] w_tecla;

`ifdef CONTROLE_ENTRADA_SINC_EN
  sincronizador_tecla u_sinc (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_tecla_valida (tecla_valida),
    .i_tecla        (tecla),
    .o_strobe       (w_strobe),
    .o_tecla        (w_tecla)
  );
`else
  assign w_strobe = tecla_valida;
  assign w_tecla  = tecla;
`endif

  // Registered state and outputs
  logic [1:0]    r_estado;
  logic [7:0]    r_a;
  logic [7:0]    r_b;
  logic [2:0]    r_codigo;
  logic          r_valido;
  logic [CW-1:0] r_cont;

  // Next-state values
  logic [1:0]    w_estado;
  logic [7:0]    w_a;
  logic [7:0]    w_b;
  logic [2:0]    w_codigo;
  logic          w_valido;
  logic [CW-1:0] w_cont;

  // Key classification
  logic w_eh_digito;
  logic w_eh_operador;
  logic w_aceita_digito;
  logic [2:0] w_op_tecla;

  assign w_eh_digito     = (w_tecla <= TECLA_DIGITO_MAX);
  assign w_eh_operador   = (w_tecla == TECLA_MAIS) || (w_tecla == TECLA_MENOS);
  assign w_aceita_digito = w_eh_digito && (r_cont < CONT_MAX);
  assign w_op_tecla      = (w_tecla == TECLA_MAIS) ? OP_SOMA : OP_SUB;

  // Decode one key against the current state
  always_comb begin
    w_estado = r_estado;
    w_a      = r_a;
    w_b      = r_b;
    w_codigo = r_codigo;
    w_cont   = r_cont;
    w_valido = 1'b0;

    if (w_strobe) begin
      if (w_tecla == TECLA_LIMPA) begin
        // Clear wins in every state and never reports completion
        w_estado = S_OPER_A;
        w_a      = 8'd0;
        w_b      = 8'd0;
        w_codigo = OP_NADA;
        w_cont   = '0;
      end else begin
        case (r_estado)
          S_OPER_A: begin
            if (w_aceita_digito) begin
              w_a    = acumula_digito(r_a, w_tecla);
              w_cont = r_cont + CONT_UM;
            end else if (w_eh_operador) begin
              w_codigo = w_op_tecla;
              w_cont   = '0;
              w_estado = S_OPER_B;
            end else if (w_tecla == TECLA_IGUAL) begin
              w_codigo = OP_PASSA_A;
              w_valido = 1'b1;
              w_estado = S_PRONTO;
            end
          end
          S_OPER_B: begin
            if (w_aceita_digito) begin
              w_b    = acumula_digito(r_b, w_tecla);
              w_cont = r_cont + CONT_UM;
            end else if (w_eh_operador && (r_cont == '0)) begin
              // Operator changes are allowed only before B has digits
              w_codigo = w_op_tecla;
            end else if (w_tecla == TECLA_IGUAL) begin
              w_valido = 1'b1;
              w_estado = S_PRONTO;
            end
          end
          S_PRONTO: begin
            // A digit starts a fresh entry; operators and '=' are ignored
            if (w_eh_digito) begin
              w_a      = {4'd0, w_tecla};
              w_b      = 8'd0;
              w_codigo = OP_NADA;
              w_cont   = CONT_UM;
              w_estado = S_OPER_A;
            end
          end
          default: begin
            w_estado = S_OPER_A;
          end
        endcase
      end
    end
  end

  // State and output registers; reset clears everything asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado <= S_OPER_A;
      r_a      <= 8'd0;
      r_b      <= 8'd0;
      r_codigo <= OP_NADA;
      r_valido <= 1'b0;
      r_cont   <= '0;
    end else begin
      r_estado <= w_estado;
      r_a      <= w_a;
      r_b      <= w_b;
      r_codigo <= w_codigo;
      r_valido <= w_valido;
      r_cont   <= w_cont;
    end
  end

  assign entrada_A = r_a;
  assign entrada_B = r_b;
  assign codigo    = r_codigo;
  assign valido    = r_valido;
  assign estado    = r_estado;

endmodule

// File: doc/controle_entrada.md
# controle_entrada

Keypad entry sequencer directly upstream of the combinational calculator. Collects decimal digit keys and operator keys from a keypad scanner, builds the two 8-bit operands and the 3-bit operation code, and presents them as registered outputs. When the user presses '=', it issues a one-cycle `valido` strobe; the downstream calculator result is meaningful from that cycle on.

## Interface
- `MAX_DIGITOS`, default 3: maximum decimal digits accepted per operand; further digits are ignored.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `tecla_valida`  in  1: key strobe. Single-cycle synchronous by default; see Configuration.
- `tecla`  in  4: key code. 0x0–0x9 digit, 0xA '+', 0xB '-', 0xC '=', 0xD clear; 0xE and 0xF are ignored.
- `entrada_A`  out  8: operand A, registered.
- `entrada_B`  out  8: operand B, registered.
- `codigo`  out  3: operation: 000 none, 001 pass A, 010 pass B, 011 A+B, 100 A−B.
- `valido`  out  1: one-cycle pulse marking that an operation is complete.
- `estado`  out  2: current FSM state, for the display: 00 OPER_A, 01 OPER_B, 10 PRONTO.

## Operation
- Reset values: all outputs 0, state OPER_A, digit counter 0.
- Digit entry:
  - Each accepted digit d updates the active operand to min(val·10 + d, 255), using a 12-bit intermediate.
  - Saturation is sticky: further digits keep the operand at 255.
  - The digit counter increments on each accepted digit.
  - Once the counter reaches MAX_DIGITOS, further digits are ignored.
- OPER_A:
  - Digit → operand A.
  - '+' or '-' → codigo = 011 or 100; clear the counter; go to OPER_B.
  - '=' → codigo = 001; pulse `valido`; go to PRONTO.
- OPER_B:
  - Digit → operand B.
  - Operator while the counter is 0 → replaces codigo (last operator wins).
  - Operator while the counter is greater than 0 → ignored.
  - '=' → pulse `valido`; go to PRONTO. If no B digit was entered, B stays 0.
- PRONTO:
  - Outputs are held stable.
  - Digit → start a new entry: A = d, B = 0, codigo = 000, counter = 1; go to OPER_A.
  - Operator and '=' → ignored.
- Clear (0xD), in any state → A = B = 0, codigo = 000, counter = 0, go to OPER_A. No `valido` pulse.
- Keys 0xE and 0xF → no effect in any state.
- `tecla_valida` low → no state change.
- Subtraction underflow is not handled here; the downstream stage wraps modulo 256.

## Timing
- A key is sampled on the rising edge of `clk` while the strobe is high.
- Outputs update on that same edge and are visible in the following cycle.
- `valido` is high for exactly the one cycle after the '=' edge. It never stays high for two consecutive cycles.
- Back-to-back strobes on consecutive cycles are all processed, with no dead cycle.
- Asserting `rst_n` mid-entry clears everything immediately, independent of `clk`.
- An in-progress `valido` pulse is truncated by reset.

## Configuration
- `CONTROLE_ENTRADA_SINC_EN` defined:
  - `tecla_valida` and `tecla` are treated as asynchronous levels from the scanner.
  - Both pass through a two-flop synchronizer; a rising-edge detect on the synchronized strobe produces the internal strobe.
  - This adds 3 cycles of latency; a held key counts once.
- Undefined: `tecla_valida` is a synchronous single-cycle strobe, used directly with zero added latency.

## Structure
- Shared package `calculadora_pkg` holds:
  - codigo constants OP_NADA, OP_PASSA_A, OP_PASSA_B, OP_SOMA, OP_SUB;
  - key-code constants TECLA_IGUAL, TECLA_LIMPA, TECLA_MAIS, TECLA_MENOS;
  - the state enum. The calculator uses the same codigo constants.
- Sub-module `sincronizador_tecla`: synchronizer plus edge detect, instantiated only under `CONTROLE_ENTRADA_SINC_EN`.

## Test plan
- Keys 1,2 '+' 3 '=' → A=12, B=3, codigo=011; `valido` high for one cycle; estado=10.
- Keys 9,9,9 → A=255 (saturated). A fourth digit 5 → A stays 255; the counter is capped at MAX_DIGITOS = 3.
- Keys 7 '+' '-' 2 '=' → codigo=100, B=2. Then '+' → ignored, codigo stays 100.
- Keys 4 '=' → codigo=001, A=4, `valido` pulse. Then digit 6 → A=6, B=0, codigo=000, estado=00.
- Keys 5 '+' 8, then clear → all outputs 0, no `valido`. Asserting rst_n low mid-entry → outputs 0 asynchronously.
- With `CONTROLE_ENTRADA_SINC_EN`, holding `tecla_valida` high for 10 cycles with tecla=3 → exactly one digit accepted, A=3, applied 3 cycles later than the unsynchronized build.
